// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared defaults, config struct and validation for clkgen_multi.
// CLKGEN_PHASE_EN adds a per-channel start phase to the config.
package clkgen_pkg;

    localparam int DEFAULT_PERIOD = 40;
    localparam int DEFAULT_HIGH   = 10;

    typedef struct packed {
        logic [31:0] period;
        logic [31:0] high;
`ifdef CLKGEN_PHASE_EN
        logic [31:0] phase;
`endif
    } cfg_t;

    function automatic logic cfg_ok(cfg_t c);
        logic ok;
        ok = c.period >= 32'd2 && c.high <= c.period;
`ifdef CLKGEN_PHASE_EN
        ok = ok && c.phase < c.period;
`endif
        return ok;
    endfunction

endpackage

// File: rtl/clkgen_channel.sv
// clkgen_channel: one period/high counter with shadow config applied at the period boundary.
// CLKGEN_PHASE_EN makes the counter restart from a stored phase instead of 0.
module clkgen_channel #(
    parameter int W          = 8,
    parameter int DEF_PERIOD = 40,
    parameter int DEF_HIGH   = 10
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         wr,
    input  logic [W-1:0] wr_period,
    input  logic [W-1:0] wr_high,
`ifdef CLKGEN_PHASE_EN
    input  logic [W-1:0] wr_phase,
`endif
    output logic         pending,
    output logic         out,
    output logic         period_tick
);
    logic [W-1:0] cnt, p, h, sh_p, sh_h, p_n, h_n, start, cnt_n;
    logic         run, apply, last;
`ifdef CLKGEN_PHASE_EN
    logic [W-1:0] ph, sh_ph;
    assign start = apply ? sh_ph : ph;
`else
    assign start = '0;
`endif

    // run remembers last cycle's enable so a rising enable restarts the count
    always_comb begin
        last  = cnt == p - W'(1);
        apply = pending && (!run || !enable || last);
        p_n   = apply ? sh_p : p;
        h_n   = apply ? sh_h : h;
        cnt_n = !enable ? '0 : (!run || apply) ? start : last ? '0 : cnt + W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            run         <= 1'b0;
            p           <= W'(DEF_PERIOD);
            h           <= W'(DEF_HIGH);
            sh_p        <= W'(DEF_PERIOD);
            sh_h        <= W'(DEF_HIGH);
            pending     <= 1'b0;
            out         <= 1'b0;
            period_tick <= 1'b0;
`ifdef CLKGEN_PHASE_EN
            ph          <= '0;
            sh_ph       <= '0;
`endif
        end else begin
            run         <= enable;
            cnt         <= cnt_n;
            p           <= p_n;
            h           <= h_n;
            pending     <= wr || (pending && !apply);
            out         <= enable && cnt_n >= p_n - h_n;
            period_tick <= enable && cnt_n == p_n - W'(1);
            if (wr) begin
                sh_p <= wr_period;
                sh_h <= wr_high;
            end
`ifdef CLKGEN_PHASE_EN
            ph <= start;
            if (wr)
                sh_ph <= wr_phase;
`endif
        end
    end

endmodule

// File: rtl/clkgen_multi.sv
// clkgen_multi: CH independent programmable waveform generators with a valid/ready config port.
// CLKGEN_PHASE_EN adds the cfg_phase input and per-channel start phase.
module clkgen_multi
    import clkgen_pkg::*;
#(
    parameter int  CH         = 2,
    parameter int  W          = 8,
    parameter int  DEF_PERIOD = DEFAULT_PERIOD,
    parameter int  DEF_HIGH   = DEFAULT_HIGH,
    localparam int CW         = CH > 1 ? $clog2(CH) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [CH-1:0] enable,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_ch,
    input  logic [W-1:0]  cfg_period,
    input  logic [W-1:0]  cfg_high,
`ifdef CLKGEN_PHASE_EN
    input  logic [W-1:0]  cfg_phase,
`endif
    output logic          cfg_err,
    output logic [CH-1:0] out,
    output logic [CH-1:0] period_tick
);
    cfg_t          c;
    logic          ok;
    logic [CH-1:0] pending, wr;

    // an out-of-range channel shifts the one-hot mask to zero, so ready stays high for it
    always_comb begin
        c        = '0;
        c.period = 32'(cfg_period);
        c.high   = 32'(cfg_high);
`ifdef CLKGEN_PHASE_EN
        c.phase  = 32'(cfg_phase);
`endif
        ok        = cfg_ok(c) && 32'(cfg_ch) < CH;
        cfg_ready = !(|(pending & (CH'(1) << cfg_ch)));
        wr        = (cfg_valid && cfg_ready && ok) ? CH'(1) << cfg_ch : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cfg_err <= 1'b0;
        else
            cfg_err <= cfg_valid && cfg_ready && !ok;
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        clkgen_channel #(
            .W          (W),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_HIGH   (DEF_HIGH)
        ) u_ch (
            .clock       (clock),
            .reset_n     (reset_n),
            .enable      (enable[i]),
            .wr          (wr[i]),
            .wr_period   (cfg_period),
            .wr_high     (cfg_high),
`ifdef CLKGEN_PHASE_EN
            .wr_phase    (cfg_phase),
`endif
            .pending     (pending[i]),
            .out         (out[i]),
            .period_tick (period_tick[i])
        );
    end

endmodule

// File: tb/tb_clkgen_multi.sv
// tb_clkgen_multi: directed checks of clkgen_multi waveforms, config handshake and reset.
// With CLKGEN_PHASE_EN defined it also checks the start-phase feature.
module tb_clkgen_multi;
    localparam int CH = 3;
    localparam int W  = 8;

    logic          clock     = 1'b0;
    logic          reset_n   = 1'b0;
    logic [CH-1:0] enable    = '0;
    logic          cfg_valid = 1'b0;
    logic [1:0]    cfg_ch    = '0;
    logic [W-1:0]  cfg_period = '0;
    logic [W-1:0]  cfg_high   = '0;
`ifdef CLKGEN_PHASE_EN
    logic [W-1:0]  cfg_phase  = '0;
`endif
    logic          cfg_ready, cfg_err;
    logic [CH-1:0] out, period_tick;

    int            checks = 0;
    int            errors = 0;
    logic [CH-1:0] ow [0:127];
    logic [CH-1:0] tw [0:127];

    always #5 clock = ~clock;

    clkgen_multi #(.CH(CH), .W(W), .DEF_PERIOD(40), .DEF_HIGH(10)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
`ifdef CLKGEN_PHASE_EN
        .cfg_phase   (cfg_phase),
`endif
        .cfg_err     (cfg_err),
        .out         (out),
        .period_tick (period_tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            ow[k] = out;
            tw[k] = period_tick;
        end
    endtask

    function automatic int highs(input int ch, input int n);
        int s = 0;
        for (int k = 0; k < n; k++) s += int'(ow[k][ch]);
        return s;
    endfunction

    function automatic int ticks(input int ch, input int n);
        int s = 0;
        for (int k = 0; k < n; k++) s += int'(tw[k][ch]);
        return s;
    endfunction

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 60 && !cfg_ready; i++) step();
        chk(tag, cfg_ready, 1);
    endtask

    initial begin
        // reset state
        step(); step();
        chk("rst_out", out, 0);
        chk("rst_tick", period_tick, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_ready", cfg_ready, 1);
        reset_n = 1'b1;

        // ch0 with defaults: 30 low / 10 high, tick every 40
        enable = 3'b001;
        run(80);
        chk("def_low29", ow[29][0], 0);
        chk("def_rise30", ow[30][0], 1);
        chk("def_high39", ow[39][0], 1);
        chk("def_wrap40", ow[40][0], 0);
        chk("def_highs", highs(0, 80), 20);
        chk("def_tick39", tw[39][0], 1);
        chk("def_tick79", tw[79][0], 1);
        chk("def_ticks", ticks(0, 80), 2);

        // mid-period write ch1 P=8 H=4
        enable = 3'b011;
        run(5);
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_period = 8'd8; cfg_high = 8'd4;
        chk("wr_ready_pre", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
        chk("wr_ready_low", cfg_ready, 0);
        chk("wr_no_err", cfg_err, 0);
        run(34);
        chk("old_low29", ow[23][1], 0);
        chk("old_high30", ow[24][1], 1);
        chk("old_tick39", tw[33][1], 1);
        chk("ready_until_bound", cfg_ready, 0);
        chk("ch0_high", ow[33][0], 1);
        chk("ch0_tick", tw[33][0], 1);
        run(16);
        chk("new_ready", cfg_ready, 1);
        chk("new_low3", ow[3][1], 0);
        chk("new_high4", ow[4][1], 1);
        chk("new_high7", ow[7][1], 1);
        chk("new_low8", ow[8][1], 0);
        chk("new_tick7", tw[7][1], 1);
        chk("new_ticks", ticks(1, 16), 2);
        chk("new_highs", highs(1, 16), 8);
        chk("ch0_unaffected", highs(0, 16), 0);

        // three rejected requests
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_period = 8'd1; cfg_high = 8'd0;
        step();
        chk("err_p1", cfg_err, 1);
        chk("err_p1_ready", cfg_ready, 1);
        cfg_period = 8'd8; cfg_high = 8'd9;
        step();
        chk("err_h_gt_p", cfg_err, 1);
        chk("err_h_ready", cfg_ready, 1);
        cfg_ch = 2'd3; cfg_high = 8'd4;
        step();
        chk("err_ch", cfg_err, 1);
        chk("err_ch_ready", cfg_ready, 1);
        cfg_valid = 1'b0; cfg_ch = 2'd1;
        step();
        chk("err_clear", cfg_err, 0);
        chk("err_no_pend", cfg_ready, 1);
        run(16);
        chk("err_wave_highs", highs(1, 16), 8);
        chk("err_wave_ticks", ticks(1, 16), 2);

        // H=0 then H=P=6
        cfg_valid = 1'b1; cfg_period = 8'd6; cfg_high = 8'd0;
        step();
        cfg_valid = 1'b0;
        wait_ready("h0_apply");
        run(12);
        chk("h0_highs", highs(1, 12), 0);
        chk("h0_tick4", tw[4][1], 1);
        chk("h0_tick10", tw[10][1], 1);
        chk("h0_ticks", ticks(1, 12), 2);
        cfg_valid = 1'b1; cfg_high = 8'd6;
        step();
        cfg_valid = 1'b0;
        wait_ready("hp_apply");
        run(12);
        chk("hp_highs", highs(1, 12), 12);
        chk("hp_tick4", tw[4][1], 1);
        chk("hp_ticks", ticks(1, 12), 2);

        // disable mid-high
        enable = 3'b001;
        step();
        chk("dis_out", out[1], 0);
        chk("dis_tick", period_tick[1], 0);

        // re-enable ch0 restarts low phase first
        enable = 3'b000;
        step();
        chk("dis0_out", out[0], 0);
        enable = 3'b001;
        run(35);
        chk("reen_low29", ow[29][0], 0);
        chk("reen_high30", ow[30][0], 1);

        // reset while a ch0 write is pending
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_period = 8'd20; cfg_high = 8'd5;
        step();
        cfg_valid = 1'b0;
        chk("pend_ready", cfg_ready, 0);
        chk("pend_high", out[0], 1);
        reset_n = 1'b0;
        #1;
        chk("arst_out", out, 0);
        chk("arst_tick", period_tick, 0);
        chk("arst_ready", cfg_ready, 1);
        step();
        reset_n = 1'b1;
        run(40);
        chk("post_low29", ow[29][0], 0);
        chk("post_high30", ow[30][0], 1);
        chk("post_tick39", tw[39][0], 1);
        chk("post_ticks", ticks(0, 40), 1);
        chk("post_ready", cfg_ready, 1);

`ifdef CLKGEN_PHASE_EN
        // start phase: P=8 H=2 phase=6
        enable = 3'b000;
        step();
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_period = 8'd8; cfg_high = 8'd2; cfg_phase = 8'd8;
        step();
        chk("ph_err", cfg_err, 1);
        cfg_phase = 8'd6;
        step();
        cfg_valid = 1'b0;
        chk("ph_ok", cfg_err, 0);
        wait_ready("ph_apply");
        enable = 3'b001;
        run(10);
        chk("ph_rise0", ow[0][0], 1);
        chk("ph_high1", ow[1][0], 1);
        chk("ph_tick1", tw[1][0], 1);
        chk("ph_low2", ow[2][0], 0);
        chk("ph_low7", ow[7][0], 0);
        chk("ph_high8", ow[8][0], 1);
        chk("ph_tick9", tw[9][0], 1);
        chk("ph_highs", highs(0, 10), 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clkgen_multi.md
# clkgen_multi

Parametrised multi-channel clock/waveform generator producing CH independent periodic outputs with programmable period and high time, counted in cycles of the system clock. Each channel is a synthesizable counter. Configuration goes through a valid/ready port and takes effect only at a period boundary, so outputs never glitch. Used in testbench and peripheral-timing subsystems wherever a derived clock, strobe or PWM-style enable is needed.

## Interface
Parameters:
- CH, 2, number of independent channels (≥1)
- W, 8, width of period/high counters
- DEF_PERIOD, 40, per-channel period loaded at reset (2..2^W-1)
- DEF_HIGH, 10, per-channel high time loaded at reset (0..DEF_PERIOD)

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  CH  per-channel run enable
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  request can be accepted this cycle
- cfg_ch  in  max(1,$clog2(CH))  target channel
- cfg_period  in  W  new period P
- cfg_high  in  W  new high time H
- cfg_err  out  1  one-cycle pulse: request rejected
- out  out  CH  generated waveforms
- period_tick  out  CH  one-cycle pulse on last cycle of each period

## Operation
- Per channel: counter cnt runs 0..P-1 while enable=1, wraps to 0.
- out=1 when cnt ≥ P-H, else 0: low for P-H cycles, then high for H cycles. Defaults give 30 low / 10 high.
- H=0: constantly low. H=P: constantly high. period_tick still pulses in both cases.
- enable=0: cnt held at 0, out=0, period_tick=0 from the next edge.
- Re-enable: restarts at cnt=0, low phase first.
- Config accept: cfg_valid && cfg_ready. Values go to a shadow register and set pending[cfg_ch].
- cfg_ready = !pending[cfg_ch].
- Validation at accept: P<2, cfg_ch≥CH, or H>P → rejected. cfg_err pulses, no state changes, pending is not set.
- Apply: on the edge where cnt==P-1, or on the next edge if the channel is disabled. Load the shadow, clear pending, wrap cnt to 0.
- Simultaneous accept and the apply edge on the same channel cannot occur, because ready is low while pending.
- Reset mid-operation: all channels return to reset state immediately. Shadows and pending are discarded.

## Timing
- Reset values: out=0, period_tick=0, cfg_err=0, cfg_ready=1, cnt=0, P=DEF_PERIOD, H=DEF_HIGH, pending=0.
- All outputs registered. out and period_tick reflect cnt of the same cycle.
- With enable held high from the first post-reset edge, out first rises after P-H enabled cycles.
- cfg_err is asserted the cycle after the rejected request.
- The new P/H govern the first cycle after the boundary edge. Worst-case apply latency is P cycles.

## Configuration
- CLKGEN_PHASE_EN defined:
  - Adds input cfg_phase (W bits), validated with the other fields; phase ≥ P is rejected.
  - It is stored per channel.
  - On enable rising, and on each apply edge, cnt loads phase instead of 0.
  - Reset phase is 0.
- Undefined: no cfg_phase port; cnt always starts at 0.

## Structure
- Package clkgen_pkg holds:
  - the default period/high constants;
  - a channel-config struct typedef {period, high[, phase]};
  - a function validating a config.
- Sub-module clkgen_channel holds one counter, active P/H registers, shadow and pending logic. The top holds the cfg decode/handshake and generates CH instances.

## Test plan
- Reset, enable ch0 with defaults → out[0] low 30 / high 10 cycles, period_tick every 40 cycles, repeating.
- Mid-period write ch1 P=8,H=4 → cfg_ready low until the boundary. The old waveform completes, then 4 low / 4 high. ch0 is unaffected.
- Write P=1, then H=9 with P=8, then cfg_ch=CH → three cfg_err pulses, no waveform change, cfg_ready stays 1.
- H=0, then H=P=6 → constant 0, then constant 1; period_tick every 6 cycles in both.
- Deassert enable mid-high, and assert reset_n=0 mid-pending → out=0 next edge. After reset: defaults restored, pending cleared.
- CLKGEN_PHASE_EN, P=8,H=2, phase=6 → first rise 0 cycles after enable, high 2 cycles, then the normal 6 low / 2 high.
